// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : audio_pkg
//  Brief    : Shared types for the audio sample scheduler (FSM states,
//             sample word type and default sample width).
//  Revision : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int AUD_DATA_W = 16;

    typedef logic [AUD_DATA_W-1:0] sample_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARMED    = 3'd1,
        INIT_REQ = 3'd2,
        STREAM   = 3'd3,
        ERROR    = 3'd4
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/prio_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : prio_arbiter
//  Brief    : Combinational fixed-priority arbiter. The highest set request
//             index wins; produces a one-hot grant, the winning index and a
//             flag telling whether any request was present.
//  Revision : 1.0 - initial release
// ============================================================================
module prio_arbiter #(
    parameter int N     = 15,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Scan upward so that a later (higher) set bit overrides earlier ones
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
                any_o    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/audio_sample_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : audio_sample_scheduler
//  Brief    : Runs the codec INIT/INIT_FINISH bring-up after a Run
//             press-and-release, then on every data_over rising edge grants
//             one requesting voice (highest index first) and registers its
//             L/R sample onto AUD_LDATA/AUD_RDATA.
//  Revision : 1.0 - initial release
// ============================================================================
module audio_sample_scheduler
    import audio_pkg::*;
#(
    parameter int NUM_VOICES   = 15,
    parameter int DATA_W       = AUD_DATA_W,
    parameter int INIT_TIMEOUT = 50_000_000,
    parameter int CNT_W        = 16,
    localparam int IDX_W       = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Run,
    input  logic [NUM_VOICES-1:0]        voice_req,
    input  logic [NUM_VOICES*DATA_W-1:0] voice_ldata,
    input  logic [NUM_VOICES*DATA_W-1:0] voice_rdata,
    output logic [NUM_VOICES-1:0]        voice_ack,
    output logic                         INIT,
    input  logic                         INIT_FINISH,
    input  logic                         data_over,
    output logic [DATA_W-1:0]            AUD_LDATA,
    output logic [DATA_W-1:0]            AUD_RDATA,
    output logic [IDX_W-1:0]             active_voice,
    output logic                         streaming,
    output logic                         init_err,
    output logic [CNT_W-1:0]             underrun_cnt
);

    localparam int              TO_W    = (INIT_TIMEOUT > 1) ? $clog2(INIT_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(INIT_TIMEOUT - 1);

    sched_state_t           state_q, state_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   dov_q;
    logic [NUM_VOICES-1:0]  ack_q, ack_d;
    logic [DATA_W-1:0]      ldata_q, ldata_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [IDX_W-1:0]       active_q, active_d;
    logic [CNT_W-1:0]       underrun_q, underrun_d;

    logic [NUM_VOICES-1:0]  w_gnt;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_any;
    logic                   w_slot;
    logic [DATA_W-1:0]      w_sel_l;
    logic [DATA_W-1:0]      w_sel_r;

    prio_arbiter #(
        .N     (NUM_VOICES),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i (voice_req),
        .gnt_o (w_gnt),
        .idx_o (w_idx),
        .any_o (w_any)
    );

    // A sample slot is a data_over rising edge seen while streaming; dov_q
    // tracks data_over in every state so a level already high on entry is ignored.
    assign w_slot = data_over & ~dov_q & (state_q == STREAM);

    // Pick the granted voice's L/R words out of the packed sample buses
    always_comb begin
        w_sel_l = '0;
        w_sel_r = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (w_gnt[i]) begin
                w_sel_l = voice_ldata[i*DATA_W +: DATA_W];
                w_sel_r = voice_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Bring-up sequencer next state and init timeout counter
    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        case (state_q)
            IDLE: begin
                if (!Run) state_d = ARMED;
            end
            ARMED: begin
                to_cnt_d = '0;
                if (Run) state_d = INIT_REQ;
            end
            INIT_REQ: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                // A finish arriving in the timeout cycle still counts as success
                if (INIT_FINISH)               state_d = STREAM;
                else if (to_cnt_q == TO_LAST)  state_d = ERROR;
            end
            STREAM: begin
                state_d = STREAM;
            end
            ERROR: begin
                if (!Run) state_d = ARMED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-slot grant: load the winner's sample or zero-fill and count an underrun
    always_comb begin
        ack_d      = '0;
        ldata_d    = ldata_q;
        rdata_d    = rdata_q;
        active_d   = active_q;
        underrun_d = underrun_q;
        if (w_slot) begin
            if (w_any) begin
                ack_d    = w_gnt;
                ldata_d  = w_sel_l;
                rdata_d  = w_sel_r;
                active_d = w_idx;
            end else begin
                ldata_d = '0;
                rdata_d = '0;
                if (underrun_q != '1) underrun_d = underrun_q + CNT_W'(1);
            end
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= IDLE;
            to_cnt_q   <= '0;
            dov_q      <= data_over;
            ack_q      <= '0;
            ldata_q    <= '0;
            rdata_q    <= '0;
            active_q   <= '0;
            underrun_q <= '0;
        end else begin
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            dov_q      <= data_over;
            ack_q      <= ack_d;
            ldata_q    <= ldata_d;
            rdata_q    <= rdata_d;
            active_q   <= active_d;
            underrun_q <= underrun_d;
        end
    end

    assign INIT         = (state_q == INIT_REQ);
    assign streaming    = (state_q == STREAM);
    assign init_err     = (state_q == ERROR);
    assign voice_ack    = ack_q;
    assign AUD_LDATA    = ldata_q;
    assign AUD_RDATA    = rdata_q;
    assign active_voice = active_q;
    assign underrun_cnt = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_sample_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_audio_sample_scheduler
//  Brief    : Directed self-checking bench for audio_sample_scheduler.
//             Inputs are driven and outputs sampled on the falling clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_audio_sample_scheduler;

    localparam int NV = 15;
    localparam int DW = 16;
    localparam int TO = 100;
    localparam int CW = 3;

    logic              Clk = 1'b0;
    logic              Reset = 1'b0;
    logic              Run = 1'b1;
    logic              INIT_FINISH = 1'b0;
    logic              data_over = 1'b0;
    logic [NV-1:0]     voice_req = '0;
    logic [NV*DW-1:0]  voice_ldata = '0;
    logic [NV*DW-1:0]  voice_rdata = '0;
    logic [NV-1:0]     voice_ack;
    logic              INIT;
    logic [DW-1:0]     AUD_LDATA;
    logic [DW-1:0]     AUD_RDATA;
    logic [3:0]        active_voice;
    logic              streaming;
    logic              init_err;
    logic [CW-1:0]     underrun_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    audio_sample_scheduler #(
        .NUM_VOICES   (NV),
        .DATA_W       (DW),
        .INIT_TIMEOUT (TO),
        .CNT_W        (CW)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .voice_req    (voice_req),
        .voice_ldata  (voice_ldata),
        .voice_rdata  (voice_rdata),
        .voice_ack    (voice_ack),
        .INIT         (INIT),
        .INIT_FINISH  (INIT_FINISH),
        .data_over    (data_over),
        .AUD_LDATA    (AUD_LDATA),
        .AUD_RDATA    (AUD_RDATA),
        .active_voice (active_voice),
        .streaming    (streaming),
        .init_err     (init_err),
        .underrun_cnt (underrun_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset = 1'b0; Run = 1'b1;
        tick(); tick();
        n_checks++; if (INIT !== 1'b0) begin n_fail++; $display("FAIL rst_init: got %b want 0", INIT); end
        n_checks++; if (streaming !== 1'b0) begin n_fail++; $display("FAIL rst_streaming: got %b want 0", streaming); end
        n_checks++; if (init_err !== 1'b0) begin n_fail++; $display("FAIL rst_init_err: got %b want 0", init_err); end
        n_checks++; if (voice_ack !== 15'h0) begin n_fail++; $display("FAIL rst_ack: got %h want 0", voice_ack); end
        n_checks++; if (AUD_LDATA !== 16'h0 || AUD_RDATA !== 16'h0) begin n_fail++; $display("FAIL rst_data: got %h/%h want 0/0", AUD_LDATA, AUD_RDATA); end
        n_checks++; if (active_voice !== 4'd0) begin n_fail++; $display("FAIL rst_active: got %0d want 0", active_voice); end
        n_checks++; if (underrun_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_underrun: got %0d want 0", underrun_cnt); end
        Reset = 1'b1;
    endtask

    task automatic test_bringup();
        Run = 1'b0;
        tick();
        n_checks++; if (INIT !== 1'b0) begin n_fail++; $display("FAIL armed_init: got %b want 0", INIT); end
        Run = 1'b1;
        tick();
        n_checks++; if (INIT !== 1'b1) begin n_fail++; $display("FAIL initreq_init: got %b want 1", INIT); end
        tick();
        n_checks++; if (INIT !== 1'b1 || streaming !== 1'b0) begin n_fail++; $display("FAIL initreq_hold: got init=%b str=%b want 1/0", INIT, streaming); end
        INIT_FINISH = 1'b1;
        tick();
        n_checks++; if (streaming !== 1'b1 || INIT !== 1'b0) begin n_fail++; $display("FAIL stream_entry: got str=%b init=%b want 1/0", streaming, INIT); end
        INIT_FINISH = 1'b0;
    endtask

    task automatic test_priority();
        voice_req = 15'h0009;
        data_over = 1'b1;
        n_checks++; if (voice_ack !== 15'h0) begin n_fail++; $display("FAIL pre_slot_ack: got %h want 0", voice_ack); end
        tick();
        n_checks++; if (AUD_LDATA !== 16'hC000 || AUD_RDATA !== 16'h5003) begin n_fail++; $display("FAIL slot_v3_data: got %h/%h want c000/5003", AUD_LDATA, AUD_RDATA); end
        n_checks++; if (voice_ack !== 15'h0008) begin n_fail++; $display("FAIL slot_v3_ack: got %h want 0008", voice_ack); end
        n_checks++; if (active_voice !== 4'd3) begin n_fail++; $display("FAIL slot_v3_active: got %0d want 3", active_voice); end
        voice_req = 15'h4000;
        tick();
        n_checks++; if (voice_ack !== 15'h0) begin n_fail++; $display("FAIL ack_one_cycle: got %h want 0", voice_ack); end
        n_checks++; if (AUD_LDATA !== 16'hC000 || active_voice !== 4'd3) begin n_fail++; $display("FAIL hold_between_slots: got %h/%0d want c000/3", AUD_LDATA, active_voice); end
        data_over = 1'b0;
        tick();
        data_over = 1'b1;
        tick();
        n_checks++; if (voice_ack !== 15'h4000 || active_voice !== 4'd14) begin n_fail++; $display("FAIL slot_v14: got ack=%h idx=%0d want 4000/14", voice_ack, active_voice); end
        n_checks++; if (AUD_LDATA !== 16'hA00E || AUD_RDATA !== 16'h500E) begin n_fail++; $display("FAIL slot_v14_data: got %h/%h want a00e/500e", AUD_LDATA, AUD_RDATA); end
        data_over = 1'b0;
        tick();
    endtask

    task automatic test_underrun();
        voice_req = '0;
        for (int k = 0; k < 3; k++) begin
            data_over = 1'b1;
            tick();
            n_checks++; if (voice_ack !== 15'h0) begin n_fail++; $display("FAIL underrun_ack: got %h want 0", voice_ack); end
            n_checks++; if (AUD_LDATA !== 16'h0 || AUD_RDATA !== 16'h0) begin n_fail++; $display("FAIL underrun_data: got %h/%h want 0/0", AUD_LDATA, AUD_RDATA); end
            data_over = 1'b0;
            tick();
        end
        n_checks++; if (underrun_cnt !== 3'd3) begin n_fail++; $display("FAIL underrun_cnt3: got %0d want 3", underrun_cnt); end
        n_checks++; if (active_voice !== 4'd14) begin n_fail++; $display("FAIL underrun_active_hold: got %0d want 14", active_voice); end
        for (int k = 0; k < 4; k++) begin
            data_over = 1'b1; tick();
            data_over = 1'b0; tick();
        end
        n_checks++; if (underrun_cnt !== 3'd7) begin n_fail++; $display("FAIL underrun_cnt7: got %0d want 7", underrun_cnt); end
        data_over = 1'b1; tick();
        data_over = 1'b0; tick();
        n_checks++; if (underrun_cnt !== 3'd7) begin n_fail++; $display("FAIL underrun_saturate: got %0d want 7", underrun_cnt); end
    endtask

    task automatic test_reset_midstream();
        voice_req = 15'h0001;
        data_over = 1'b1;
        tick();
        n_checks++; if (voice_ack !== 15'h0001 || AUD_LDATA !== 16'hA000) begin n_fail++; $display("FAIL v0_slot: got ack=%h l=%h want 0001/a000", voice_ack, AUD_LDATA); end
        Reset = 1'b0;
        tick();
        n_checks++; if (voice_ack !== 15'h0 || AUD_LDATA !== 16'h0 || AUD_RDATA !== 16'h0) begin n_fail++; $display("FAIL midrst_data: got ack=%h l=%h r=%h want 0/0/0", voice_ack, AUD_LDATA, AUD_RDATA); end
        n_checks++; if (active_voice !== 4'd0 || underrun_cnt !== 3'd0) begin n_fail++; $display("FAIL midrst_regs: got idx=%0d ur=%0d want 0/0", active_voice, underrun_cnt); end
        n_checks++; if (streaming !== 1'b0 || INIT !== 1'b0 || init_err !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got str=%b init=%b err=%b want 0/0/0", streaming, INIT, init_err); end
        Reset = 1'b1; data_over = 1'b0; voice_req = '0; Run = 1'b1;
        tick(); tick();
        n_checks++; if (streaming !== 1'b0 || INIT !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got str=%b init=%b want 0/0", streaming, INIT); end
    endtask

    task automatic test_timeout();
        Run = 1'b0; tick();
        Run = 1'b1; tick();
        n_checks++; if (INIT !== 1'b1) begin n_fail++; $display("FAIL to_enter: got %b want 1", INIT); end
        repeat (TO - 1) tick();
        n_checks++; if (INIT !== 1'b1 || init_err !== 1'b0) begin n_fail++; $display("FAIL to_cycle99: got init=%b err=%b want 1/0", INIT, init_err); end
        tick();
        n_checks++; if (init_err !== 1'b1 || INIT !== 1'b0 || streaming !== 1'b0) begin n_fail++; $display("FAIL to_error: got err=%b init=%b str=%b want 1/0/0", init_err, INIT, streaming); end
        Run = 1'b0; tick();
        n_checks++; if (init_err !== 1'b0 || INIT !== 1'b0) begin n_fail++; $display("FAIL retry_armed: got err=%b init=%b want 0/0", init_err, INIT); end
        Run = 1'b1; tick();
        n_checks++; if (INIT !== 1'b1) begin n_fail++; $display("FAIL retry_init: got %b want 1", INIT); end
        repeat (TO - 1) tick();
        INIT_FINISH = 1'b1;
        tick();
        n_checks++; if (streaming !== 1'b1 || init_err !== 1'b0) begin n_fail++; $display("FAIL finish_wins: got str=%b err=%b want 1/0", streaming, init_err); end
        INIT_FINISH = 1'b0;
    endtask

    task automatic test_dov_held();
        Reset = 1'b0; data_over = 1'b1; tick();
        Reset = 1'b1; Run = 1'b0; tick();
        Run = 1'b1; tick();
        INIT_FINISH = 1'b1; voice_req = 15'h0020;
        tick();
        INIT_FINISH = 1'b0;
        n_checks++; if (streaming !== 1'b1 || voice_ack !== 15'h0) begin n_fail++; $display("FAIL dov_entry: got str=%b ack=%h want 1/0", streaming, voice_ack); end
        tick(); tick();
        n_checks++; if (voice_ack !== 15'h0 || AUD_LDATA !== 16'h0 || active_voice !== 4'd0) begin n_fail++; $display("FAIL dov_no_slot: got ack=%h l=%h idx=%0d want 0/0/0", voice_ack, AUD_LDATA, active_voice); end
        data_over = 1'b0; tick();
        n_checks++; if (voice_ack !== 15'h0) begin n_fail++; $display("FAIL dov_fall: got %h want 0", voice_ack); end
        data_over = 1'b1; tick();
        n_checks++; if (voice_ack !== 15'h0020 || active_voice !== 4'd5 || AUD_LDATA !== 16'hA005) begin n_fail++; $display("FAIL dov_rise: got ack=%h idx=%0d l=%h want 0020/5/a005", voice_ack, active_voice, AUD_LDATA); end
    endtask

    initial begin
        for (int i = 0; i < NV; i++) begin
            voice_ldata[i*DW +: DW] = {4'hA, 12'(i)};
            voice_rdata[i*DW +: DW] = {4'h5, 12'(i)};
        end
        voice_ldata[3*DW +: DW] = 16'hC000;
        test_reset();
        test_bringup();
        test_priority();
        test_underrun();
        test_reset_midstream();
        test_timeout();
        test_dov_held();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
